sram_counter_bank: RTL and testbench

Parametrised successor to the single-width SRAM multi-counter. Holds NUM_CNT counters of CNT_W bits in one dual-port SRAM (port 0 read, port 1 write). Commands are pipelined at one per cycle with same-id forwarding. Adds the following over the fixed 256x8 block:
- valid/ready input handshake
- post-reset zeroing sweep
- ADD/SUB by operand
- selectable wrap or saturate arithmetic
- registered response path

---
 rtl/sram_counter_bank.sv | 178 +++++++++++++++++
 tb/tb_sram_counter_bank.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_counter_bank.sv
// NUM_CNT x CNT_W counters in a 1R1W SRAM. One command per cycle, READ answers at accept+2, no response backpressure.
// Zeroing sweep after reset. `CNT_BANK_OVF_FLAG_EN adds the rsp_ovf/ovf_id wrap/clamp report.
module sram_counter_bank #(
   parameter int NUM_CNT  = 256,
   parameter int CNT_W    = 8,
   parameter int ID_W     = $clog2(NUM_CNT),
   parameter int SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ID_W-1:0]  in_id,
   input  logic [2:0]       in_cmd,
   input  logic [CNT_W-1:0] in_data,
   output logic             rsp_valid,
   output logic [ID_W-1:0]  rsp_id,
   output logic [CNT_W-1:0] rsp_data
`ifdef CNT_BANK_OVF_FLAG_EN
   ,
   output logic             rsp_ovf,
   output logic [ID_W-1:0]  ovf_id
`endif
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [2:0] C_LOAD  = 3'b000;
   localparam logic [2:0] C_CLEAR = 3'b001;
   localparam logic [2:0] C_INC   = 3'b010;
   localparam logic [2:0] C_DEC   = 3'b011;
   localparam logic [2:0] C_READ  = 3'b100;
   localparam logic [2:0] C_ADD   = 3'b101;
   localparam logic [2:0] C_SUB   = 3'b110;

   logic [0:0]       state;
   logic [ID_W-1:0]  sweep_addr;
   logic [CNT_W-1:0] mem [NUM_CNT];
   logic [CNT_W-1:0] rd_dat;

   logic             p1_vld;
   logic [ID_W-1:0]  p1_id;
   logic [2:0]       p1_cmd;
   logic [CNT_W-1:0] p1_dat;

   logic             fwd_vld;
   logic [ID_W-1:0]  fwd_id;
   logic [CNT_W-1:0] fwd_dat;

   logic             accept;
   logic             p1_wr;
   logic             p1_rd;
   logic             arith;
   logic             up;
   logic [CNT_W-1:0] old_val;
   logic [CNT_W-1:0] opnd;
   logic [CNT_W-1:0] new_val;
   logic [CNT_W:0]   sum;

   logic             wr_en;
   logic [ID_W-1:0]  wr_addr;
   logic [CNT_W-1:0] wr_dat;

   assign in_ready = (state == ST_RUN);
   assign accept   = in_valid & in_ready;
   assign p1_rd    = p1_vld && (p1_cmd == C_READ);

   // Read-during-write on the same address returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_dat;
      rd_dat <= mem[in_id];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_INIT;
         sweep_addr <= '0;
         p1_vld     <= 1'b0;
         fwd_vld    <= 1'b0;
      end else begin
         if (state == ST_INIT) begin
            sweep_addr <= sweep_addr + 1'b1;
            if (sweep_addr == ID_W'(NUM_CNT - 1))
               state <= ST_RUN;
         end
         p1_vld  <= accept;
         fwd_vld <= p1_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         p1_id  <= in_id;
         p1_cmd <= in_cmd;
         p1_dat <= in_data;
      end
      if (p1_wr) begin
         fwd_id  <= p1_id;
         fwd_dat <= new_val;
      end
   end

   // The write from the previous P1 lands on the same edge this command's read was issued, so take it from fwd.
   always_comb begin
      old_val = (fwd_vld && (fwd_id == p1_id)) ? fwd_dat : rd_dat;
      opnd    = ((p1_cmd == C_INC) || (p1_cmd == C_DEC)) ? CNT_W'(1) : p1_dat;
      p1_wr   = p1_vld;
      arith   = 1'b0;
      up      = 1'b0;
      sum     = '0;
      new_val = old_val;
      case (p1_cmd)
         C_LOAD:  new_val = p1_dat;
         C_CLEAR: new_val = '0;
         C_INC, C_ADD: begin
            arith = 1'b1;
            up    = 1'b1;
            sum   = {1'b0, old_val} + {1'b0, opnd};
         end
         C_DEC, C_SUB: begin
            arith = 1'b1;
            sum   = {1'b0, old_val} - {1'b0, opnd};
         end
         default: p1_wr = 1'b0;
      endcase
      if (arith) begin
         if (sum[CNT_W] && (SATURATE != 0))
            new_val = up ? '1 : '0;
         else
            new_val = sum[CNT_W-1:0];
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = sweep_addr;
      wr_dat  = '0;
      if (!rst) begin
         if (state == ST_INIT) begin
            wr_en = 1'b1;
         end else if (p1_wr) begin
            wr_en   = 1'b1;
            wr_addr = p1_id;
            wr_dat  = new_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= p1_rd;
         if (p1_rd) begin
            rsp_id   <= p1_id;
            rsp_data <= old_val;
         end
      end
   end

`ifdef CNT_BANK_OVF_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_ovf <= 1'b0;
         ovf_id  <= '0;
      end else begin
         rsp_ovf <= p1_vld && arith && sum[CNT_W];
         if (p1_vld && arith && sum[CNT_W])
            ovf_id <= p1_id;
      end
   end
`endif

endmodule

// File: tb/tb_sram_counter_bank.sv
// Three sram_counter_bank instances (256x8 wrap, 16x8 saturate, 16x16 wrap) share one command stream
// and are compared against a per-instance array model of counter values.
module tb_sram_counter_bank;

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] id;
      logic [31:0] data;
   } rsp_t;

   localparam logic [2:0] LOAD = 3'd0, CLEAR = 3'd1, INC = 3'd2, DEC = 3'd3;
   localparam logic [2:0] READ = 3'd4, ADD = 3'd5, SUB = 3'd6, RSVD = 3'd7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_id = '0;
   logic [2:0]  in_cmd = '0;
   logic [15:0] in_data = '0;

   logic        a_rdy, s_rdy, w_rdy, a_vld, s_vld, w_vld;
   logic [7:0]  a_id;
   logic [3:0]  s_id, w_id;
   logic [7:0]  a_dat, s_dat;
   logic [15:0] w_dat;
`ifdef CNT_BANK_OVF_FLAG_EN
   logic        a_ovf, s_ovf, w_ovf;
   logic [7:0]  a_oid;
   logic [3:0]  s_oid, w_oid;
`endif

   int   vec = 0;
   int   err = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   mdl [3][256];
   rsp_t exp_q [3][$];
   rsp_t got_q [3][$];
   rsp_t ovf_exp [3][$];
   rsp_t ovf_got [3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_counter_bank dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .in_id(in_id),
      .in_cmd(in_cmd), .in_data(in_data[7:0]), .rsp_valid(a_vld), .rsp_id(a_id), .rsp_data(a_dat)
`ifdef CNT_BANK_OVF_FLAG_EN
      , .rsp_ovf(a_ovf), .ovf_id(a_oid)
`endif
   );

   sram_counter_bank #(.NUM_CNT(16), .CNT_W(8), .SATURATE(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_rdy), .in_id(in_id[3:0]),
      .in_cmd(in_cmd), .in_data(in_data[7:0]), .rsp_valid(s_vld), .rsp_id(s_id), .rsp_data(s_dat)
`ifdef CNT_BANK_OVF_FLAG_EN
      , .rsp_ovf(s_ovf), .ovf_id(s_oid)
`endif
   );

   sram_counter_bank #(.NUM_CNT(16), .CNT_W(16), .SATURATE(0)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_rdy), .in_id(in_id[3:0]),
      .in_cmd(in_cmd), .in_data(in_data), .rsp_valid(w_vld), .rsp_id(w_id), .rsp_data(w_dat)
`ifdef CNT_BANK_OVF_FLAG_EN
      , .rsp_ovf(w_ovf), .ovf_id(w_oid)
`endif
   );

   function automatic rsp_t mk(input int c, input int i, input int d);
      rsp_t r;
      r.cyc  = c;
      r.id   = i;
      r.data = d;
      return r;
   endfunction

   function automatic int idm(input int k);
      return (k == 0) ? 255 : 15;
   endfunction

   // Counter semantics as plain integer arithmetic on a w-bit counter.
   function automatic int step(input logic [2:0] c, input int old, input int d, input int w,
                               input bit sat, output bit wr, output bit ovf);
      int mx;
      int r;
      mx  = (1 << w) - 1;
      r   = old;
      wr  = 1'b1;
      ovf = 1'b0;
      case (c)
         LOAD:    r = d;
         CLEAR:   r = 0;
         INC:     r = old + 1;
         DEC:     r = old - 1;
         ADD:     r = old + d;
         SUB:     r = old - d;
         default: wr = 1'b0;
      endcase
      if (r > mx) begin
         ovf = 1'b1;
         r   = sat ? mx : r - (mx + 1);
      end else if (r < 0) begin
         ovf = 1'b1;
         r   = sat ? 0 : r + mx + 1;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (a_vld) got_q[0].push_back(mk(cyc, int'(a_id), int'(a_dat)));
      if (s_vld) got_q[1].push_back(mk(cyc, int'(s_id), int'(s_dat)));
      if (w_vld) got_q[2].push_back(mk(cyc, int'(w_id), int'(w_dat)));
`ifdef CNT_BANK_OVF_FLAG_EN
      if (a_ovf) ovf_got[0].push_back(mk(cyc, int'(a_oid), 0));
      if (s_ovf) ovf_got[1].push_back(mk(cyc, int'(s_oid), 0));
      if (w_ovf) ovf_got[2].push_back(mk(cyc, int'(w_oid), 0));
`endif
   end

   task automatic zero_models();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 256; i++)
            mdl[k][i] = 0;
   endtask

   task automatic clear_logs();
      for (int k = 0; k < 3; k++) begin
         exp_q[k].delete();
         got_q[k].delete();
         ovf_exp[k].delete();
         ovf_got[k].delete();
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives one command for one cycle and advances every model.
   task automatic issue(input logic [2:0] c, input int id, input int d);
      int  i, w, o, nv;
      bit  wr, ov;
      in_valid = 1'b1;
      in_cmd   = c;
      in_id    = id[7:0];
      in_data  = d[15:0];
      last_acc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i  = id & idm(k);
         w  = (k == 2) ? 16 : 8;
         o  = mdl[k][i];
         nv = step(c, o, d & ((1 << w) - 1), w, (k == 1), wr, ov);
         if (wr) mdl[k][i] = nv;
         if (c == READ) exp_q[k].push_back(mk(last_acc + 2, i, o));
         if (ov) ovf_exp[k].push_back(mk(last_acc + 2, i, 0));
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!(a_rdy && s_rdy && w_rdy) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      vec++;
      if (!(a_rdy && s_rdy && w_rdy)) begin
         err++;
         $display("FAIL ready_timeout: in_ready a/s/w=%b%b%b after %0d cycles, want 111", a_rdy, s_rdy, w_rdy, n);
      end
   endtask

   task automatic test_reset();
      int   na, nw, acc;
      bit   da, dw;
      rsp_t g, e;
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      vec++;
      if (a_rdy !== 1'b0 || a_vld !== 1'b0 || a_id !== 8'h00 || a_dat !== 8'h00) begin
         err++;
         $display("FAIL reset_values: rdy=%b vld=%b id=%h data=%h, want 0 0 00 00", a_rdy, a_vld, a_id, a_dat);
      end
      rst = 1'b0;
      zero_models();
      na = 0; nw = 0; da = 0; dw = 0;
      for (int i = 0; i < 400 && !(da && dw); i++) begin
         @(negedge clk);
         if (!da) begin if (a_rdy) da = 1; else na++; end
         if (!dw) begin if (w_rdy) dw = 1; else nw++; end
      end
      vec++;
      if (na !== 256) begin err++; $display("FAIL sweep_len_256: in_ready low %0d cycles, want 256", na); end
      vec++;
      if (nw !== 16) begin err++; $display("FAIL sweep_len_16: in_ready low %0d cycles, want 16", nw); end
      @(posedge clk);
      #1;
      clear_logs();
      issue(READ, 'h37, 0);
      acc = last_acc;
      idle(3);
      for (int k = 0; k < 3; k++) begin
         e = mk(acc + 2, 'h37 & idm(k), 0);
         g = (got_q[k].size() > 0) ? got_q[k].pop_front() : '0;
         vec++;
         if (g !== e) begin
            err++;
            $display("FAIL post_sweep_read dut%0d: got cyc %0d id %0h data %0h, want cyc %0d id %0h data %0h",
                     k, g.cyc, g.id, g.data, e.cyc, e.id, e.data);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   r1, r2;
      rsp_t g, e;
      clear_logs();
      issue(LOAD, 5, 10);
      repeat (3) issue(INC, 5, 0);
      issue(READ, 5, 0);
      r1 = last_acc;
      issue(READ, 5, 0);
      r2 = last_acc;
      idle(3);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 2; j++) begin
            e = mk(((j == 0) ? r1 : r2) + 2, 5, 13);
            g = (got_q[k].size() > 0) ? got_q[k].pop_front() : '0;
            vec++;
            if (g !== e) begin
               err++;
               $display("FAIL b2b_inc dut%0d rsp%0d: got cyc %0d id %0h data %0h, want cyc %0d id %0h data %0h",
                        k, j, g.cyc, g.id, g.data, e.cyc, e.id, e.data);
            end
         end
      end
   endtask

   task automatic test_gap_forward();
      int   r1, r2;
      int   want2 [3];
      rsp_t g, e;
      want2 = '{4, 255, 260};
      clear_logs();
      issue(LOAD, 9, 200);
      issue(INC, 'h22, 0);
      issue(ADD, 9, 50);
      issue(READ, 9, 0);
      r1 = last_acc;
      issue(ADD, 9, 10);
      issue(READ, 9, 0);
      r2 = last_acc;
      idle(3);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 2; j++) begin
            e = (j == 0) ? mk(r1 + 2, 9, 250) : mk(r2 + 2, 9, want2[k]);
            g = (got_q[k].size() > 0) ? got_q[k].pop_front() : '0;
            vec++;
            if (g !== e) begin
               err++;
               $display("FAIL gap_add dut%0d rsp%0d: got cyc %0d id %0h data %0h, want cyc %0d id %0h data %0h",
                        k, j, g.cyc, g.id, g.data, e.cyc, e.id, e.data);
            end
         end
      end
   endtask

   task automatic test_saturate();
      int   r1, r2, add_acc, dec_acc;
      int   want1 [3];
      int   want2 [3];
      rsp_t g, e;
      want1 = '{4, 255, 260};
      want2 = '{255, 0, 65535};
      clear_logs();
      issue(LOAD, 'h41, 250);
      issue(ADD, 'h41, 10);
      add_acc = last_acc;
      issue(READ, 'h41, 0);
      r1 = last_acc;
      issue(CLEAR, 'h41, 0);
      issue(DEC, 'h41, 0);
      dec_acc = last_acc;
      issue(READ, 'h41, 0);
      r2 = last_acc;
      idle(3);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 2; j++) begin
            e = (j == 0) ? mk(r1 + 2, 'h41 & idm(k), want1[k]) : mk(r2 + 2, 'h41 & idm(k), want2[k]);
            g = (got_q[k].size() > 0) ? got_q[k].pop_front() : '0;
            vec++;
            if (g !== e) begin
               err++;
               $display("FAIL sat_clamp dut%0d rsp%0d: got cyc %0d id %0h data %0h, want cyc %0d id %0h data %0h",
                        k, j, g.cyc, g.id, g.data, e.cyc, e.id, e.data);
            end
         end
      end
`ifdef CNT_BANK_OVF_FLAG_EN
      for (int j = 0; j < 2; j++) begin
         e = mk(((j == 0) ? add_acc : dec_acc) + 2, 1, 0);
         g = (ovf_got[1].size() > 0) ? ovf_got[1].pop_front() : '0;
         vec++;
         if (g !== e) begin
            err++;
            $display("FAIL sat_ovf pulse%0d: got cyc %0d ovf_id %0h, want cyc %0d ovf_id %0h", j, g.cyc, g.id, e.cyc, e.id);
         end
      end
      vec++;
      if (ovf_got[1].size() != 0) begin
         err++;
         $display("FAIL sat_ovf_extra: %0d extra pulses, want 0", ovf_got[1].size());
      end
`else
      if (add_acc == dec_acc) $display("note: accept cycles coincide");
`endif
   endtask

   task automatic test_wrap_variant();
      int   r1, r2;
      int   want [3];
      rsp_t g, e;
      want = '{0, 255, 0};
      clear_logs();
      issue(LOAD, 15, 'hFFFF);
      issue(INC, 15, 0);
      issue(READ, 15, 0);
      r1 = last_acc;
      issue(RSVD, 15, 'h1234);
      issue(READ, 15, 0);
      r2 = last_acc;
      idle(3);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 2; j++) begin
            e = mk(((j == 0) ? r1 : r2) + 2, 15, want[k]);
            g = (got_q[k].size() > 0) ? got_q[k].pop_front() : '0;
            vec++;
            if (g !== e) begin
               err++;
               $display("FAIL wrap_rsvd dut%0d rsp%0d: got cyc %0d id %0h data %0h, want cyc %0d id %0h data %0h",
                        k, j, g.cyc, g.id, g.data, e.cyc, e.id, e.data);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int   acc;
      rsp_t g, e;
      clear_logs();
      issue(LOAD, 3, 7);
      idle(1);
      issue(INC, 3, 0);
      issue(READ, 3, 0);
      rst = 1'b1;
      idle(2);
      for (int k = 0; k < 3; k++) begin
         vec++;
         if (got_q[k].size() != 0) begin
            err++;
            $display("FAIL reset_drops_read dut%0d: %0d responses, want 0", k, got_q[k].size());
         end
      end
      rst = 1'b0;
      zero_models();
      wait_ready();
      clear_logs();
      issue(READ, 3, 0);
      acc = last_acc;
      idle(3);
      for (int k = 0; k < 3; k++) begin
         e = mk(acc + 2, 3, 0);
         g = (got_q[k].size() > 0) ? got_q[k].pop_front() : '0;
         vec++;
         if (g !== e) begin
            err++;
            $display("FAIL reset_resweep dut%0d: got cyc %0d id %0h data %0h, want cyc %0d id %0h data %0h",
                     k, g.cyc, g.id, g.data, e.cyc, e.id, e.data);
         end
      end
   endtask

   task automatic test_random();
      int         id;
      logic [2:0] c;
      rsp_t       g, e;
      clear_logs();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            idle(1);
         end else begin
            id = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            c  = ($urandom_range(0, 2) == 0) ? READ : 3'($urandom_range(0, 7));
            issue(c, id, int'($urandom_range(0, 65535)));
         end
      end
      idle(3);
      for (int k = 0; k < 3; k++) begin
         vec++;
         if (got_q[k].size() != exp_q[k].size()) begin
            err++;
            $display("FAIL rand_count dut%0d: %0d responses, want %0d", k, got_q[k].size(), exp_q[k].size());
         end
         while (exp_q[k].size() > 0) begin
            e = exp_q[k].pop_front();
            g = (got_q[k].size() > 0) ? got_q[k].pop_front() : '0;
            vec++;
            if (g !== e) begin
               err++;
               $display("FAIL rand_rsp dut%0d: got cyc %0d id %0h data %0h, want cyc %0d id %0h data %0h",
                        k, g.cyc, g.id, g.data, e.cyc, e.id, e.data);
            end
         end
`ifdef CNT_BANK_OVF_FLAG_EN
         vec++;
         if (ovf_got[k].size() != ovf_exp[k].size()) begin
            err++;
            $display("FAIL rand_ovf_count dut%0d: %0d pulses, want %0d", k, ovf_got[k].size(), ovf_exp[k].size());
         end
         while (ovf_exp[k].size() > 0) begin
            e = ovf_exp[k].pop_front();
            g = (ovf_got[k].size() > 0) ? ovf_got[k].pop_front() : '0;
            vec++;
            if (g !== e) begin
               err++;
               $display("FAIL rand_ovf dut%0d: got cyc %0d ovf_id %0h, want cyc %0d ovf_id %0h", k, g.cyc, g.id, e.cyc, e.id);
            end
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gap_forward();
      test_saturate();
      test_wrap_variant();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
